// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Action encoding and control priority encoder for pc_stack.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

    typedef logic [2:0] act_t;

    localparam act_t ACT_HOLD  = 3'd0;
    localparam act_t ACT_INC   = 3'd1;
    localparam act_t ACT_LOAD  = 3'd2;
    localparam act_t ACT_CALL  = 3'd3;
    localparam act_t ACT_RET   = 3'd4;
    localparam act_t ACT_CLEAR = 3'd5;

    // Exactly one action per edge: clear > ret > call > load > inc > hold.
    function automatic act_t encode_action(input logic clear, input logic ret,
                                           input logic call, input logic load,
                                           input logic inc);
        act_t act;
        if (clear)     act = ACT_CLEAR;
        else if (ret)  act = ACT_RET;
        else if (call) act = ACT_CALL;
        else if (load) act = ACT_LOAD;
        else if (inc)  act = ACT_INC;
        else           act = ACT_HOLD;
        return act;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_stack_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_stack_if
// Description : Control/address bundle between CPU decode and pc_stack.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_stack_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    logic                     clear;
    logic                     load;
    logic                     inc;
    logic                     call;
    logic                     ret;
    logic [WIDTH-1:0]         in;
    logic [WIDTH-1:0]         out;
    logic [$clog2(DEPTH):0]   sp;
    logic                     full;
    logic                     empty;
    logic                     overflow;
    logic                     underflow;

    modport master (
        output clear, load, inc, call, ret, in,
        input  out, sp, full, empty, overflow, underflow
    );

    modport slave (
        input  clear, load, inc, call, ret, in,
        output out, sp, full, empty, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/lifo_stack.sv
`default_nettype none
// ============================================================================
// Module      : lifo_stack
// Description : Return-address LIFO with combinational top-of-stack read.
// Revision    : 1.0 - initial release
// ============================================================================
module lifo_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  wire logic                     clock,
    input  wire logic                     reset,
    input  wire logic                     clr,
    input  wire logic                     push,
    input  wire logic                     pop,
    input  wire logic [WIDTH-1:0]         din,
    output logic      [WIDTH-1:0]         dout,
    output logic      [$clog2(DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      count_q, count_d;
    logic [AW-1:0]    top_idx;

    // Count of DEPTH wraps the low bits to 0, so top_idx lands on DEPTH-1.
    assign top_idx = count_q[AW-1:0] - {{(AW-1){1'b0}}, 1'b1};
    assign dout    = mem_q[top_idx];
    assign count   = count_q;
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);

    always_comb begin
        count_d = count_q;
        if (clr)       count_d = '0;
        else if (pop)  count_d = count_q - {{AW{1'b0}}, 1'b1};
        else if (push) count_d = count_q + {{AW{1'b0}}, 1'b1};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) count_q <= '0;
        else        count_q <= count_d;
    end

    always_ff @(posedge clock) begin
        if (push && !clr && !pop) mem_q[count_q[AW-1:0]] <= din;
    end
endmodule
`default_nettype wire

// File: rtl/pc_stack.sv
`default_nettype none
// ============================================================================
// Module      : pc_stack
// Description : Hack-style program counter with return-address stack and
//               sticky stack-fault flags.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_stack
    import pc_pkg::*;
#(
    parameter int                 WIDTH        = 16,
    parameter int                 DEPTH        = 8,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = '0
) (
    input  wire logic   clock,
    input  wire logic   reset,
    pc_stack_if.slave   bus
);
    act_t             act;
    logic [WIDTH-1:0] out_q, out_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             stk_push, stk_pop, stk_clr;
    logic [WIDTH-1:0] stk_top;
    logic             stk_full, stk_empty;

    assign act = encode_action(bus.clear, bus.ret, bus.call, bus.load, bus.inc);

    always_comb begin
        out_d       = out_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        stk_clr     = 1'b0;
        case (act)
            ACT_CLEAR: begin
                out_d       = RESET_VECTOR;
                overflow_d  = 1'b0;
                underflow_d = 1'b0;
                stk_clr     = 1'b1;
            end
            ACT_RET: begin
                if (stk_empty) begin
                    underflow_d = 1'b1;
                end else begin
                    out_d   = stk_top;
                    stk_pop = 1'b1;
                end
            end
            ACT_CALL: begin
                // The jump is taken even when the push has to be dropped.
                out_d = bus.in;
                if (stk_full) overflow_d = 1'b1;
                else          stk_push   = 1'b1;
            end
            ACT_LOAD: out_d = bus.in;
            ACT_INC:  out_d = out_q + WIDTH'(1);
            default:  out_d = out_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_q       <= RESET_VECTOR;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    lifo_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lifo (
        .clock (clock),
        .reset (reset),
        .clr   (stk_clr),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (out_q + WIDTH'(1)),
        .dout  (stk_top),
        .count (bus.sp),
        .full  (stk_full),
        .empty (stk_empty)
    );

    assign bus.out       = out_q;
    assign bus.full      = stk_full;
    assign bus.empty     = stk_empty;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule
`default_nettype wire
